// File: rtl/quick_spi_slave_if.sv
// Parallel handshake + SPI pin bundle for quick_spi_slave.
interface quick_spi_slave_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cpol;
  logic                  cpha;
  logic                  sclk;
  logic                  mosi;
  logic                  ss_n;
  logic                  miso;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  busy;
  logic                  tx_underrun;
  logic                  rx_overrun;
  logic                  clear_flags;

  modport slave (
    input  cpol, cpha, sclk, mosi, ss_n, tx_data, tx_valid, rx_ready, clear_flags,
    output miso, tx_ready, rx_data, rx_valid, busy, tx_underrun, rx_overrun
  );

  modport master (
    output cpol, cpha, sclk, mosi, ss_n, tx_data, tx_valid, rx_ready, clear_flags,
    input  miso, tx_ready, rx_data, rx_valid, busy, tx_underrun, rx_overrun
  );
endinterface

// File: rtl/quick_spi_slave.sv
// Oversampling LSB-first SPI slave with one-entry TX holding and RX output registers.
// QUICK_SPI_SLAVE_MISO_TRISTATE_EN: release miso (1'bz) while deselected.
module quick_spi_slave #(
  parameter int DATA_WIDTH = 8
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  quick_spi_slave_if.slave  bus
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

  state_e                state_q, state_d;
  logic [1:0]            sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic                  sclk_dly_q;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  miso_q, miso_d;
  logic                  unr_q, unr_d, ovr_q, ovr_d;

  logic                  sclk_s, mosi_s, ss_s, sclk_edge, lead, trail, sample, shift;
  logic [DATA_WIDTH-1:0] rx_word;

  assign sclk_s    = sclk_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign ss_s      = ss_sync_q[1];
  assign sclk_edge = sclk_s ^ sclk_dly_q;
  assign lead      = sclk_edge & (sclk_s != cpol_q);
  assign trail     = sclk_edge & (sclk_s == cpol_q);
  assign sample    = cpha_q ? trail : lead;
  assign shift     = cpha_q ? lead : trail;

  always_comb begin
    rx_word           = rx_sr_q;
    rx_word[LAST]     = mosi_s;
  end

  always_comb begin
    state_d     = state_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    cnt_d       = cnt_q;
    tx_sr_d     = tx_sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    miso_d      = miso_q;
    unr_d       = unr_q & ~bus.clear_flags;
    ovr_d       = ovr_q & ~bus.clear_flags;

    if (bus.tx_valid && !hold_full_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
    if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!ss_s) begin
          cpol_d  = bus.cpol;
          cpha_d  = bus.cpha;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d = '0;
        if (ss_s) begin
          state_d = IDLE;
        end else begin
          // Holding is never written while full, so emptying it here cannot lose a write.
          if (hold_full_q) begin
            tx_sr_d     = hold_q;
            hold_full_d = 1'b0;
          end else begin
            tx_sr_d = '0;
            unr_d   = 1'b1;
          end
          if (!cpha_q) miso_d = hold_full_q & hold_q[0];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_s) begin
          state_d = IDLE;
          cnt_d   = '0;
          rx_sr_d = '0;
        end else begin
          if (shift) miso_d = tx_sr_q[cnt_q];
          if (sample) begin
            rx_sr_d[cnt_q] = mosi_s;
            cnt_d          = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = LOAD;
              // A same-cycle consumer read frees the output register for the new word.
              if (!rx_valid_q || bus.rx_ready) begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
              end else begin
                ovr_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= 2'b11;
      sclk_dly_q  <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      cnt_q       <= '0;
      tx_sr_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      unr_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= {sclk_sync_q[0], bus.sclk};
      mosi_sync_q <= {mosi_sync_q[0], bus.mosi};
      ss_sync_q   <= {ss_sync_q[0], bus.ss_n};
      sclk_dly_q  <= sclk_s;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      cnt_q       <= cnt_d;
      tx_sr_q     <= tx_sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      unr_q       <= unr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.tx_ready    = ~hold_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = unr_q;
  assign bus.rx_overrun  = ovr_q;
`ifdef QUICK_SPI_SLAVE_MISO_TRISTATE_EN
  assign bus.miso = bus.busy ? miso_q : 1'bz;
`else
  assign bus.miso = bus.busy & miso_q;
`endif

endmodule

// File: tb/tb_quick_spi_slave.sv
// Directed bench for quick_spi_slave: bench-side SPI master plus word-level model of the slave.
module tb_quick_spi_slave;
  localparam int HALF = 6;

  logic clk, rst_n;
  quick_spi_slave_if #(.DATA_WIDTH(8)) bus ();
  quick_spi_slave #(.DATA_WIDTH(8)) dut (.s_axi_aclk(clk), .s_axi_aresetn(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 0;
  int rises = 0;
  logic rv_prev = 1'b0;

`ifdef QUICK_SPI_SLAVE_MISO_TRISTATE_EN
  localparam logic MISO_IDLE = 1'bz;
`else
  localparam logic MISO_IDLE = 1'b0;
`endif

  // word-level model of the slave
  logic [7:0] m_rx_data, m_hold, m_next_tx;
  logic       m_rx_valid, m_hold_full, m_unr, m_ovr, m_sel;

  task automatic model_reset();
    m_rx_data = 0; m_hold = 0; m_next_tx = 0;
    m_rx_valid = 0; m_hold_full = 0; m_unr = 0; m_ovr = 0; m_sel = 0;
  endtask

  task automatic model_load();
    if (m_hold_full) begin m_next_tx = m_hold; m_hold_full = 0; end
    else begin m_next_tx = 8'h00; m_unr = 1; end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (bus.rx_valid && !rv_prev) rises++;
    rv_prev <= bus.rx_valid;
  end

  always @(negedge clk) begin
    #1;
    if (chk_en && rst_n) begin
      check("cyc_rx_data", bus.rx_data, m_rx_data);
      check("cyc_rx_valid", bus.rx_valid, m_rx_valid);
      check("cyc_tx_ready", bus.tx_ready, !m_hold_full);
      check("cyc_tx_underrun", bus.tx_underrun, m_unr);
      check("cyc_rx_overrun", bus.rx_overrun, m_ovr);
      check("cyc_busy", bus.busy, m_sel);
      if (!m_sel) check("cyc_miso_idle", bus.miso, MISO_IDLE);
    end
  end

  task automatic tx_write(input logic [7:0] d);
    int n = 0;
    while (!bus.tx_ready && n < 40) begin tick(1); n++; end
    if (!bus.tx_ready) begin
      checks++; errors++;
      $display("FAIL tx_ready_timeout: got 0 expected 1");
    end
    bus.tx_data = d; bus.tx_valid = 1; tick(1); bus.tx_valid = 0;
    m_hold = d; m_hold_full = 1;
  endtask

  task automatic rx_read();
    bus.rx_ready = 1; tick(1); bus.rx_ready = 0;
    m_rx_valid = 0;
  endtask

  task automatic clear_flags();
    bus.clear_flags = 1; tick(1); bus.clear_flags = 0;
    m_unr = 0; m_ovr = 0;
  endtask

  task automatic select(input logic pol, input logic pha);
    chk_en = 0;
    bus.cpol = pol; bus.cpha = pha; bus.sclk = pol;
    tick(4);
    bus.ss_n = 0; tick(6);
    model_load(); m_sel = 1;
  endtask

  task automatic deselect();
    tick(HALF); bus.ss_n = 1; m_sel = 0;
    tick(6); chk_en = 1;
  endtask

  task automatic after_sample(input bit pulse_ready);
    if (pulse_ready) begin
      tick(2); bus.rx_ready = 1; tick(1); bus.rx_ready = 0; tick(HALF - 3);
    end else tick(HALF);
  endtask

  // bench master: drives bits LSB first, captures miso just before each sample edge
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit rdy_last, output logic [7:0] mi);
    logic [7:0] w = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!bus.cpha) begin
        bus.mosi = mo[i]; tick(HALF);
        w[i] = bus.miso; bus.sclk = ~bus.cpol;
        after_sample(rdy_last && i == 7);
        bus.sclk = bus.cpol;
      end else begin
        bus.sclk = ~bus.cpol; bus.mosi = mo[i]; tick(HALF);
        w[i] = bus.miso; bus.sclk = bus.cpol;
        after_sample(rdy_last && i == 7);
      end
    end
    mi = w;
    if (nbits == 8) begin
      check("master_rx_word", mi, m_next_tx);
      if (rdy_last || !m_rx_valid) begin m_rx_data = mo; m_rx_valid = 1; end
      else m_ovr = 1;
      model_load();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mi;
    int r0;
    model_reset();
    rst_n = 0;
    bus.cpol = 0; bus.cpha = 0; bus.sclk = 0; bus.mosi = 0; bus.ss_n = 1;
    bus.tx_data = 0; bus.tx_valid = 0; bus.rx_ready = 0; bus.clear_flags = 0;
    tick(3);
    check("rst_tx_ready", bus.tx_ready, 1);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_flags", {bus.tx_underrun, bus.rx_overrun}, 0);
    check("rst_miso", bus.miso, MISO_IDLE);
    rst_n = 1; tick(3); chk_en = 1;

    // mode 0 single word, holding refilled mid-word so the next load is not an underrun
    tx_write(8'hA5); select(0, 0); tx_write(8'h5A);
    xfer(8'h3C, 8, 0, mi);
    check("t1_master_lit", mi, 8'hA5);
    deselect();
    check("t1_rx_data_lit", bus.rx_data, 8'h3C);
    check("t1_rx_valid_lit", bus.rx_valid, 1);
    check("t1_flags_lit", {bus.tx_underrun, bus.rx_overrun}, 0);
    rx_read();

    for (int m = 1; m < 4; m++) begin
      logic [1:0] mb;
      mb = 2'(m);
      tx_write(8'h81); select(mb[1], mb[0]); tx_write(8'h00);
      xfer(8'h7E, 8, 0, mi);
      check("t2_master_lit", mi, 8'h81);
      deselect();
      check("t2_rx_data_lit", bus.rx_data, 8'h7E);
      rx_read();
    end

    // back-to-back, no refill, no rx read
    tx_write(8'h11); select(0, 0);
    xfer(8'hC3, 8, 0, mi);
    check("t3_w1_lit", mi, 8'h11);
    xfer(8'h3A, 8, 0, mi);
    check("t3_w2_lit", mi, 8'h00);
    deselect();
    check("t3_rx_data_lit", bus.rx_data, 8'hC3);
    check("t3_flags_lit", {bus.tx_underrun, bus.rx_overrun}, 2'b11);
    clear_flags(); tick(1);
    check("t3_clear_lit", {bus.tx_underrun, bus.rx_overrun}, 2'b00);
    rx_read();

    // aborted word after 3 bits, then a full word
    r0 = rises;
    select(0, 0);
    xfer(8'hFF, 3, 0, mi);
    deselect();
    check("t4_busy_between", bus.busy, 0);
    select(0, 0);
    xfer(8'h55, 8, 0, mi);
    deselect();
    check("t4_rx_data_lit", bus.rx_data, 8'h55);
    check("t4_rx_events", rises - r0, 1);

    // consumer read coincident with the next word completing
    clear_flags();
    select(0, 0);
    xfer(8'h99, 8, 1, mi);
    deselect();
    check("t5_rx_data_lit", bus.rx_data, 8'h99);
    check("t5_rx_valid_lit", bus.rx_valid, 1);
    check("t5_overrun_lit", bus.rx_overrun, 0);

    // asynchronous reset mid-word
    tx_write(8'hA5); select(0, 1);
    xfer(8'hF0, 3, 0, mi);
    bus.sclk = ~bus.cpol;
    #2 rst_n = 0;
    #1;
    check("t6_tx_ready", bus.tx_ready, 1);
    check("t6_rx_valid", bus.rx_valid, 0);
    check("t6_rx_data", bus.rx_data, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_flags", {bus.tx_underrun, bus.rx_overrun}, 0);
    check("t6_miso", bus.miso, MISO_IDLE);
    model_reset();
    bus.ss_n = 1; bus.sclk = 0; bus.mosi = 0; bus.cpha = 0;
    tick(2); rst_n = 1; tick(4); chk_en = 1;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
